// File: rtl/d_ff_monitor.sv
// rtl/d_ff_monitor.sv - receive-side checker that predicts and compares a D flop's q/q_o
module d_ff_monitor #(
  parameter int NUM_CHECKS  = 16,
  parameter int CNT_W       = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             dut_rst_n,
  input  logic             q,
  input  logic             q_o,
  output logic             mismatch,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] NUM_CHK = CNT_W'(NUM_CHECKS);

  state_t           state;
  state_t           state_nxt;
  logic             exp_vld;
  logic             exp_q;
  logic             exp_qo;
  logic             do_cmp;
  logic             cmp_fail;
  logic             chk_hit;
  logic [CNT_W-1:0] chk_nxt;
  logic [CNT_W-1:0] err_nxt;

  // Compare the flop outputs against last cycle's prediction; X/Z on q or q_o fails
  always_comb begin
    do_cmp   = exp_vld && (state == RUN);
    cmp_fail = do_cmp && ((q !== exp_q) || (q_o !== exp_qo));
    chk_nxt  = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNT_ONE;
    err_nxt  = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_ONE;
    chk_hit  = do_cmp && (chk_nxt == NUM_CHK);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: reaching the check budget wins over halting on an error
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (chk_hit) begin
          state_nxt = DONE;
        end else if (cmp_fail && (STOP_ON_ERR != 0)) begin
          state_nxt = HALT;
        end
      end
      DONE:    state_nxt = DONE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Verdict outputs decoded from the state
  always_comb begin
    done = (state == DONE) || (state == HALT);
    pass = (state == DONE) && (err_cnt == '0);
  end

  // Prediction stage: a flop held in reset drives both outputs low, not complements
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_vld <= 1'b0;
      exp_q   <= 1'b0;
      exp_qo  <= 1'b0;
    end else if ((state == IDLE) || (state == RUN)) begin
      exp_vld <= en;
      exp_q   <= dut_rst_n & d;
      exp_qo  <= dut_rst_n & ~d;
    end else begin
      exp_vld <= 1'b0;
    end
  end

  // Saturating check/error counters, first-failure index and mismatch pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch      <= 1'b0;
      chk_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      mismatch <= 1'b0;
      if (do_cmp) begin
        chk_cnt <= chk_nxt;
        if (cmp_fail) begin
          mismatch <= 1'b1;
          err_cnt  <= err_nxt;
          if (err_cnt == '0) begin
            first_err_idx <= chk_cnt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_d_ff_monitor.sv
// tb/tb_d_ff_monitor.sv - directed plus randomized self-checking bench for d_ff_monitor
module tb_d_ff_monitor;

  localparam int NCHK = 16;

  logic       clk;
  logic       rst;
  logic       en;
  logic       d;
  logic       dut_rst_n;
  logic       q;
  logic       q_o;

  logic       mismatch0, done0, pass0;
  logic [7:0] chk_cnt0, err_cnt0, first_err_idx0;
  logic       mismatch1, done1, pass1;
  logic [7:0] chk_cnt1, err_cnt1, first_err_idx1;

  int errors = 0;
  int checks = 0;

  d_ff_monitor #(.NUM_CHECKS(NCHK), .CNT_W(8), .STOP_ON_ERR(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .d(d), .dut_rst_n(dut_rst_n), .q(q), .q_o(q_o),
    .mismatch(mismatch0), .chk_cnt(chk_cnt0), .err_cnt(err_cnt0),
    .first_err_idx(first_err_idx0), .done(done0), .pass(pass0)
  );

  d_ff_monitor #(.NUM_CHECKS(NCHK), .CNT_W(8), .STOP_ON_ERR(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .d(d), .dut_rst_n(dut_rst_n), .q(q), .q_o(q_o),
    .mismatch(mismatch1), .chk_cnt(chk_cnt1), .err_cnt(err_cnt1),
    .first_err_idx(first_err_idx1), .done(done1), .pass(pass1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit running;
    bit fin_done;
    bit fin_halt;
    bit pv;
    bit pd;
    bit prstn;
    int chk;
    int err;
    int first;
    bit mis;
  } mdl_t;

  mdl_t m [2];
  bit   last_d;
  bit   last_rstn;

  function automatic mdl_t mdl_clear();
    mdl_t n;
    n = '{default: 0};
    return n;
  endfunction

  // One clock of the checker's contract: sample -> compare next cycle -> verdict
  function automatic mdl_t mstep(input mdl_t mi, input bit stop, input bit r, input bit e,
                                 input bit dd, input bit rn, input logic qq, input logic qo);
    mdl_t n;
    bit   idle;
    bit   fail;
    logic eq;
    logic eqo;
    n = mi;
    n.mis = 1'b0;
    if (r) return mdl_clear();
    idle = !mi.running && !mi.fin_done && !mi.fin_halt;
    if (mi.running && mi.pv) begin
      eq   = mi.prstn ? logic'(mi.pd) : 1'b0;
      eqo  = mi.prstn ? logic'(!mi.pd) : 1'b0;
      fail = !((qq === eq) && (qo === eqo));
      n.chk = (mi.chk < 255) ? mi.chk + 1 : mi.chk;
      if (fail) begin
        if (mi.err == 0) n.first = mi.chk;
        n.err = (mi.err < 255) ? mi.err + 1 : mi.err;
        n.mis = 1'b1;
      end
      if (n.chk == NCHK) begin
        n.running  = 1'b0;
        n.fin_done = 1'b1;
      end else if (fail && stop) begin
        n.running  = 1'b0;
        n.fin_halt = 1'b1;
      end
    end
    if (idle || mi.running) begin
      n.pv    = e;
      n.pd    = dd;
      n.prstn = rn;
      if (idle && e) n.running = 1'b1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("mismatch0", int'(mismatch0), int'(m[0].mis));
    check("chk_cnt0", int'(chk_cnt0), m[0].chk);
    check("err_cnt0", int'(err_cnt0), m[0].err);
    check("first_err_idx0", int'(first_err_idx0), m[0].first);
    check("done0", int'(done0), int'(m[0].fin_done || m[0].fin_halt));
    check("pass0", int'(pass0), int'(m[0].fin_done && (m[0].err == 0)));
    check("mismatch1", int'(mismatch1), int'(m[1].mis));
    check("chk_cnt1", int'(chk_cnt1), m[1].chk);
    check("err_cnt1", int'(err_cnt1), m[1].err);
    check("first_err_idx1", int'(first_err_idx1), m[1].first);
    check("done1", int'(done1), int'(m[1].fin_done || m[1].fin_halt));
    check("pass1", int'(pass1), int'(m[1].fin_done && (m[1].err == 0)));
  endtask

  // fault: 0 correct flop, 1 q_o copies q, 2 q_o stuck high, 3 q inverted
  task automatic step(input bit r, input bit e, input bit dd, input bit rn, input int fault);
    logic qv;
    logic qov;
    qv  = last_rstn ? logic'(last_d) : 1'b0;
    qov = last_rstn ? logic'(!last_d) : 1'b0;
    case (fault)
      1:       qov = qv;
      2:       qov = 1'b1;
      3:       qv  = ~qv;
      default: ;
    endcase
    rst       = r;
    en        = e;
    d         = dd;
    dut_rst_n = rn;
    q         = qv;
    q_o       = qov;
    @(posedge clk);
    m[0] = mstep(m[0], 1'b0, r, e, dd, rn, qv, qov);
    m[1] = mstep(m[1], 1'b1, r, e, dd, rn, qv, qov);
    last_d    = dd;
    last_rstn = rn;
    #1;
    check_all();
  endtask

  initial begin
    int mis_seen;
    bit rb;
    rst = 1'b1; en = 1'b0; d = 1'b0; dut_rst_n = 1'b1; q = 1'b0; q_o = 1'b1;
    last_d = 1'b0; last_rstn = 1'b1;
    m[0] = mdl_clear();
    m[1] = mdl_clear();

    // reset state
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("reset_chk", int'(chk_cnt0), 0);
    check("reset_done", int'(done0), 0);

    // d = 1,0,1,1 with a correct flop, then en low lets the last compare finish
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    check("four_chk", int'(chk_cnt0), 4);
    check("four_err", int'(err_cnt0), 0);
    for (int i = 0; i < 13; i++) step(0, 1, 1'($urandom_range(0, 1)), 1, 0);
    check("full_done", int'(done0), 1);
    check("full_pass", int'(pass0), 1);
    check("full_chk", int'(chk_cnt0), 16);
    for (int i = 0; i < 3; i++) step(0, 1, 1'($urandom_range(0, 1)), 1, 3);
    check("done_hold_chk", int'(chk_cnt0), 16);
    check("done_hold_mis", int'(mismatch0), 0);

    // broken complement on the 3rd compare, keep running
    step(1, 0, 0, 1, 0);
    mis_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1'($urandom_range(0, 1)), 1, (i == 3) ? 1 : 0);
      if (mismatch0) mis_seen++;
    end
    check("bc_pulses", mis_seen, 1);
    check("bc_err", int'(err_cnt0), 1);
    check("bc_first", int'(first_err_idx0), 2);
    check("bc_pass", int'(pass0), 0);
    check("bc_done", int'(done0), 1);

    // flop in reset must drive both outputs low; q_o high is an error
    step(1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 2);
    step(0, 0, 1, 0, 2);
    check("rstflop_bad_err", int'(err_cnt0), 2);
    step(1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("rstflop_ok_err", int'(err_cnt0), 0);
    check("rstflop_ok_chk", int'(chk_cnt0), 2);

    // stop-on-error: fault on compare 5, further stimulus must change nothing
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 14; i++)
      step(0, 1, 1'($urandom_range(0, 1)), 1, (i == 5) ? 3 : ((i > 5) ? int'($urandom_range(0, 3)) : 0));
    check("halt_chk", int'(chk_cnt1), 5);
    check("halt_err", int'(err_cnt1), 1);
    check("halt_first", int'(first_err_idx1), 4);
    check("halt_done", int'(done1), 1);
    check("halt_pass", int'(pass1), 0);

    // reset mid-run with a sample pending
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1'($urandom_range(0, 1)), 1, 0);
    check("mid_chk7", int'(chk_cnt0), 7);
    step(1, 1, 1, 1, 0);
    check("mid_rst_chk", int'(chk_cnt0), 0);
    check("mid_rst_done", int'(done0), 0);
    step(0, 0, 0, 1, 3);
    check("mid_no_stale", int'(chk_cnt0), 0);
    check("mid_no_stale_mis", int'(mismatch0), 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    check("mid_restart", int'(chk_cnt0), 2);

    // randomized runs against the model
    for (int run = 0; run < 6; run++) begin
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < 40; i++) begin
        rb = ($urandom_range(0, 99) < 2);
        step(rb, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 99) < 85),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/d_ff_monitor.md
Name: d_ff_monitor

Overview:
Self-checking receive-side monitor for the D flip-flop test bench. It observes the stimulus driven into the flop (d, flop reset) and the flop outputs (q, q_o) one cycle later. It predicts the expected outputs, compares them, and counts checks and errors. It reports a pass/fail verdict after a programmed number of checks. It sits beside the flop in the test top and is the consumer end of the flop's d to q/q_o interface.

Parameters:
NUM_CHECKS, 16, number of compared cycles after which the verdict is issued (1 to 2^CNT_W-1)
CNT_W, 8, width of the check and error counters
STOP_ON_ERR, 0, 1 = freeze in HALT on the first mismatch; 0 = keep checking to NUM_CHECKS

Ports:
clk  in  1  clock, shared with the flop under test
rst  in  1  synchronous reset, active-high
en  in  1  monitor enable; samples the stimulus this cycle
d  in  1  data driven into the flop this cycle
dut_rst_n  in  1  flop's synchronous active-low reset as driven this cycle
q  in  1  flop output
q_o  in  1  flop complementary output
mismatch  out  1  one-cycle pulse when a compare fails
chk_cnt  out  CNT_W  number of compares performed
err_cnt  out  CNT_W  number of failed compares
first_err_idx  out  CNT_W  chk_cnt value at the first failure
done  out  1  verdict valid
pass  out  1  done and err_cnt==0

Behaviour:
- Reset: clk and rst are the only clock and reset. rst high at a rising edge clears all of the following: state=IDLE, exp_vld=0, exp_q=0, exp_qo=0, mismatch=0, chk_cnt=0, err_cnt=0, first_err_idx=0, done=0, pass=0. This applies mid-operation too; any in-flight prediction is discarded.
- Prediction stage, each edge while state is IDLE or RUN:
  - exp_vld <= en.
  - exp_q <= dut_rst_n ? d : 0.
  - exp_qo <= dut_rst_n ? ~d : 0. When the flop is in reset, both outputs are expected to be 0; they are not complements.
- Compare: in the cycle after a sample, if exp_vld=1 and the state is RUN, compare (q, q_o) with (exp_q, exp_qo). Fixed latency is one clock from sample to compare.
- Compare fail: registered outputs at the next edge:
  - mismatch=1 for one cycle.
  - err_cnt increments, saturating at 2^CNT_W-1.
  - first_err_idx <= chk_cnt, only when err_cnt was 0.
- Every compare increments chk_cnt, saturating.
- FSM:
  - IDLE: go to RUN when en=1. The first sample is captured in the same edge.
  - RUN, chk_cnt reaches NUM_CHECKS: go to DONE. The NUM_CHECKS-th compare is counted, then the state changes.
  - RUN, mismatch and STOP_ON_ERR=1: go to HALT. That failing compare is counted.
  - RUN, en=0: no new sample; the pending compare still completes. Stay in RUN.
  - DONE: done=1; pass=(err_cnt==0). Hold until rst.
  - HALT: done=1, pass=0; counters frozen. Hold until rst.
- Simultaneous events: a mismatch on the NUM_CHECKS-th compare goes to DONE with pass=0, even if STOP_ON_ERR=1. DONE takes priority over HALT.
- In DONE or HALT, en, d and q are ignored and mismatch stays 0.
- X/Z on q or q_o counts as a mismatch: compare with the case-equality operator in simulation. Synthesizable logic otherwise.

Test Plan:
- Reset, then en=1 with d=1,0,1,1 (dut_rst_n=1) and a correct flop: chk_cnt reaches 4, err_cnt=0, no mismatch pulses.
- NUM_CHECKS=16 with random d and a correct flop: done=1 and pass=1 in the cycle after the 16th compare; chk_cnt=16.
- Force q_o=q (broken complement) on the 3rd compare, STOP_ON_ERR=0: mismatch pulses once, err_cnt=1, first_err_idx=2, final pass=0.
- dut_rst_n=0 for 2 samples with d=1: expect q=0 and q_o=0. A flop that drives q_o=1 in reset is flagged (err_cnt=2). A correct flop gives err_cnt=0.
- STOP_ON_ERR=1, error on compare 5: HALT, done=1, pass=0, chk_cnt frozen at 5. Further stimulus changes nothing.
- Assert rst mid-run after 7 compares with one pending sample: all outputs are 0 next cycle, no stale compare occurs, and a restart counts from 0.
